// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM encoding, default sizes and the grant decode helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DSIZE = 8;
    localparam int DEF_BURST = 4;

    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1.
// Purely combinational; the search wraps around the request vector.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [NREQ-1:0] pick
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between requesters.
// Grants bounded bursts; one dead cycle always separates grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DSIZE = DEF_DSIZE,
    parameter int BURST = DEF_BURST,
    parameter int CNTW  = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*DSIZE-1:0] din,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull
);

    localparam int PW = $clog2(NREQ);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            req_g;
    logic            last_g;
    logic            rel;
    logic            pick_valid;
    logic [NREQ-1:0] pick;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign gidx   = PW'(onehot2idx(8'(gnt)));
    assign req_g  = req[gidx];
    assign last_g = last[gidx];
    assign busy   = (state == XFER);
    assign winc   = busy & req_g & ~wfull;
    assign ack    = winc ? gnt : '0;
    assign wdata  = (gnt != '0) ? din[int'(gidx)*DSIZE +: DSIZE] : '0;

    // Stall on wfull holds the grant; only a dropped request releases then.
    assign rel = busy & ((winc & last_g)
                       | (winc & (cnt == CNTW'(BURST - 1)))
                       | ~req_g);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= PW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= XFER;
                        gnt   <= pick;
                        cnt   <= '0;
                    end
                end
                XFER: begin
                    if (rel) begin
                        state <= IDLE;
                        gnt   <= '0;
                        cnt   <= '0;
                        ptr   <= gidx;
                    end else if (winc) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus
// randomized traffic checked against a transaction-level owner model.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       last;
    logic [NREQ*DSIZE-1:0] din;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  wfull;

    int total = 0;
    int bad   = 0;

    // Model: owner index (-1 = nobody), words written by owner, last owner.
    int owner;
    int words;
    int prev_owner;

    logic [NREQ-1:0] obs_gnt[$];
    int              obs_winc[$];

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .DSIZE (DSIZE),
        .BURST (BURST),
        .CNTW  (4)
    ) dut (
        .wclk  (wclk),
        .wrst  (wrst),
        .req   (req),
        .last  (last),
        .din   (din),
        .ack   (ack),
        .gnt   (gnt),
        .busy  (busy),
        .winc  (winc),
        .wdata (wdata),
        .wfull (wfull)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sum_winc();
        int s = 0;
        foreach (obs_winc[i]) s += obs_winc[i];
        return s;
    endfunction

    // Called at a negedge with inputs already applied.
    task automatic cycle();
        logic [NREQ-1:0]  e_gnt;
        logic [NREQ-1:0]  e_ack;
        logic             e_winc;
        logic [DSIZE-1:0] e_wdata;
        int               pick;
        #1;
        e_gnt   = '0;
        e_ack   = '0;
        e_winc  = 1'b0;
        e_wdata = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_winc       = req[owner] && !wfull;
            e_wdata      = din[owner*DSIZE +: DSIZE];
            if (e_winc) e_ack[owner] = 1'b1;
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("winc", 32'(winc), 32'(e_winc));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("wdata", 32'(wdata), 32'(e_wdata));
        obs_gnt.push_back(gnt);
        obs_winc.push_back(int'(winc));
        if (owner < 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (pick < 0 && req[(prev_owner + k) % NREQ])
                    pick = (prev_owner + k) % NREQ;
            end
            if (pick >= 0) begin
                owner = pick;
                words = 0;
            end
        end else begin
            if (e_winc) words++;
            if ((e_winc && last[owner]) || words == BURST || !req[owner]) begin
                prev_owner = owner;
                owner      = -1;
            end
        end
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        owner      = -1;
        words      = 0;
        prev_owner = NREQ - 1;
        @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        obs_gnt.delete();
        obs_winc.delete();
    endtask

    initial begin
        wrst  = 1'b1;
        req   = '0;
        last  = '0;
        din   = '0;
        wfull = 1'b0;
        @(negedge wclk);

        // Two requesters: 0 then 2 with a dead cycle between.
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            din = $urandom;
            cycle();
        end
        chk("t1_gnt1", 32'(obs_gnt[1]), 32'h1);
        chk("t1_burst0", 32'(obs_winc[1] + obs_winc[2] + obs_winc[3]
            + obs_winc[4]), 32'd4);
        chk("t1_dead", 32'(obs_gnt[5]), 32'h0);
        chk("t1_gnt6", 32'(obs_gnt[6]), 32'h4);

        // Everyone requesting: strict rotation, 4 words each.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            din = $urandom;
            cycle();
        end
        chk("t2_g0", 32'(obs_gnt[1]), 32'h1);
        chk("t2_g1", 32'(obs_gnt[6]), 32'h2);
        chk("t2_g2", 32'(obs_gnt[11]), 32'h4);
        chk("t2_g3", 32'(obs_gnt[16]), 32'h8);
        chk("t2_wincs", 32'(sum_winc()), 32'd16);

        // Requester 2 ends its packet on the second word.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            din  = $urandom;
            last = (c == 2) ? 4'b0100 : 4'b0000;
            cycle();
        end
        last = '0;
        chk("t3_wincs", 32'(sum_winc()), 32'd2);
        chk("t3_rel", 32'(obs_gnt[3]), 32'h0);

        // FIFO full for 3 cycles after the first word.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            din   = $urandom;
            wfull = (c >= 2 && c <= 4);
            cycle();
        end
        wfull = 1'b0;
        chk("t4_held", 32'(obs_gnt[4]), 32'h2);
        chk("t4_stall", 32'(obs_winc[3]), 32'd0);
        chk("t4_wincs", 32'(sum_winc()), 32'd4);
        chk("t4_rel", 32'(obs_gnt[8]), 32'h0);

        // Requester 1 drops its request after one word.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            din = $urandom;
            req = (c < 2) ? 4'b0010 : 4'b0000;
            cycle();
        end
        chk("t5_wincs", 32'(sum_winc()), 32'd1);
        chk("t5_rel", 32'(obs_gnt[3]), 32'h0);

        // Reset in the middle of a burst, then restart from requester 0.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            din = $urandom;
            cycle();
        end
        chk("t6_pre", 32'(sum_winc()), 32'd2);
        req = 4'b1111;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            din = $urandom;
            cycle();
        end
        chk("t6_first", 32'(obs_gnt[1]), 32'h1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            din   = $urandom;
            req   = NREQ'($urandom) | NREQ'($urandom);
            last  = NREQ'($urandom) & NREQ'($urandom);
            wfull = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
